// File: rtl/histo_thresh_engine_pkg.sv
// Shared types and default widths for the histogram/threshold engine.
//   DEF_PIX_W / DEF_CNT_W / DEF_PCT_W : default gray, bin-count and percentile widths
//   state_e : engine FSM states
//   mode_e  : pixel threshold modes
package histo_thresh_engine_pkg;

  localparam int unsigned DEF_PIX_W = 8;
  localparam int unsigned DEF_CNT_W = 20;
  localparam int unsigned DEF_PCT_W = 8;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SCAN  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_BIN     = 2'd0,
    MODE_INV     = 2'd1,
    MODE_GRAY    = 2'd2,
    MODE_BIN_ALT = 2'd3
  } mode_e;

endpackage

// File: rtl/histo_thresh_engine_if.sv
// Pixel/control/read-back bundle of the histogram/threshold engine.
//   master : pixel source, frame control, percentile, mode, display read address
//   slave  : the engine; returns histograms, threshold, thresholded pixel, status
interface histo_thresh_engine_if #(
  parameter int unsigned PIX_W = histo_thresh_engine_pkg::DEF_PIX_W,
  parameter int unsigned CNT_W = histo_thresh_engine_pkg::DEF_CNT_W,
  parameter int unsigned PCT_W = histo_thresh_engine_pkg::DEF_PCT_W
);

  logic [PIX_W-1:0] gray;
  logic             gray_valid;
  logic             fval;
  logic [PCT_W-1:0] percent;
  logic [1:0]       mode;
  logic [PIX_W-1:0] read_addr;
  logic [CNT_W-1:0] histo;
  logic [CNT_W-1:0] cum_histo;
  logic [PIX_W-1:0] thresh;
  logic             thresh_valid;
  logic [PIX_W-1:0] pixel;
  logic             pixel_valid;
  logic             busy;
  logic             frame_drop;

  modport master (
    output gray, gray_valid, fval, percent, mode, read_addr,
    input  histo, cum_histo, thresh, thresh_valid, pixel, pixel_valid, busy, frame_drop
  );

  modport slave (
    input  gray, gray_valid, fval, percent, mode, read_addr,
    output histo, cum_histo, thresh, thresh_valid, pixel, pixel_valid, busy, frame_drop
  );

endinterface

// File: rtl/histo_thresh_engine_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Contents are not reset; the engine clears them explicitly.
//   clk          : clock
//   we/waddr/wdata : write port
//   raddr/rdata  : read port, rdata valid one cycle after raddr
module histo_thresh_engine_ram #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 20
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  // Read returns the pre-write value on a same-address collision.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/histo_thresh_engine.sv
// Histogram/threshold engine: accumulates a per-frame gray histogram into
// ping-pong banks, scans the finished bank for the cumulative histogram and a
// percentile threshold, serves display read-back and thresholds the live stream.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : histo_thresh_engine_if slave (pixels, frame control, read-back, status)
module histo_thresh_engine
  import histo_thresh_engine_pkg::*;
#(
  parameter int unsigned PIX_W = DEF_PIX_W,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned PCT_W = DEF_PCT_W
) (
  input logic                  clk,
  input logic                  rst,
  histo_thresh_engine_if.slave bus
);

  localparam int unsigned NBINS = 2 ** PIX_W;
  localparam int unsigned TOT_W = CNT_W + PIX_W;
  localparam int unsigned SCW   = PIX_W + 1;
  localparam int unsigned PRW   = TOT_W + PCT_W;

  state_e             state;
  logic [PIX_W-1:0]   init_idx;
  logic [SCW-1:0]     scan_cnt;
  logic               drain_cnt;
  logic               bank_sel;      // bank currently accumulating; the other is displayed
  logic               fval_d;
  logic               s1_valid;
  logic [PIX_W-1:0]   s1_addr;
  logic               s2_valid;
  logic [PIX_W-1:0]   s2_addr;
  logic [CNT_W-1:0]   s2_data;
  logic [TOT_W-1:0]   total;
  logic [TOT_W-1:0]   target;
  logic [CNT_W-1:0]   cum;
  logic               found;
  logic [PIX_W-1:0]   cand;
  logic               disp_own_q;    // last display-bank read served read-back, not the scan
  logic               disp_sel_q;

  logic [CNT_W-1:0]   histo_q;
  logic [CNT_W-1:0]   cum_histo_q;
  logic [PIX_W-1:0]   thresh_q;
  logic               thresh_valid_q;
  logic [PIX_W-1:0]   pixel_q;
  logic               pixel_valid_q;
  logic               busy_q;
  logic               frame_drop_q;

  logic [1:0]         bank_we;
  logic [PIX_W-1:0]   bank_waddr [2];
  logic [CNT_W-1:0]   bank_wdata [2];
  logic [PIX_W-1:0]   bank_raddr [2];
  logic [CNT_W-1:0]   bank_rdata [2];
  logic               cum_we;
  logic [PIX_W-1:0]   cum_waddr;
  logic [CNT_W-1:0]   cum_wdata;
  logic [CNT_W-1:0]   cum_rdata;

  logic               fval_rise;
  logic               fval_fall;
  logic               acc_hit;
  logic               scan_issue;
  logic               scan_acc;
  logic [PIX_W-1:0]   scan_addr;
  logic [PIX_W-1:0]   acc_idx;
  logic [CNT_W-1:0]   acc_rdata;
  logic [CNT_W-1:0]   disp_rdata;
  logic [CNT_W-1:0]   inc_base;
  logic [CNT_W-1:0]   inc_val;
  logic [CNT_W:0]     cum_sum;
  logic [CNT_W-1:0]   cum_next;
  logic               hit_now;
  logic [PRW-1:0]     prod;
  logic [PIX_W-1:0]   pix_next;

  assign bus.histo        = histo_q;
  assign bus.cum_histo    = cum_histo_q;
  assign bus.thresh       = thresh_q;
  assign bus.thresh_valid = thresh_valid_q;
  assign bus.pixel        = pixel_q;
  assign bus.pixel_valid  = pixel_valid_q;
  assign bus.busy         = busy_q;
  assign bus.frame_drop   = frame_drop_q;

  // Frame edges, pixel qualification and scan pipeline indices.
  always_comb begin
    fval_rise  = bus.fval & ~fval_d;
    fval_fall  = ~bus.fval & fval_d;
    // The pixel on the rising-edge cycle already belongs to the new frame.
    acc_hit    = bus.gray_valid & bus.fval &
                 ((state == ST_ACCUM) | ((state == ST_IDLE) & fval_rise));
    scan_issue = (state == ST_SCAN) && !scan_cnt[PIX_W];
    scan_acc   = (state == ST_SCAN) && (scan_cnt != '0);
    scan_addr  = scan_cnt[PIX_W-1:0];
    acc_idx    = PIX_W'(scan_cnt - SCW'(1));
    acc_rdata  = bank_rdata[bank_sel];
    disp_rdata = bank_rdata[~bank_sel];
  end

  // RMW increment; forwards the previous write when the RAM read was stale.
  always_comb begin
    inc_base = (s2_valid && (s2_addr == s1_addr)) ? s2_data : acc_rdata;
    inc_val  = (&inc_base) ? inc_base : inc_base + CNT_W'(1);
  end

  // Saturating cumulative sum and first-crossing detect.
  always_comb begin
    cum_sum  = {1'b0, cum} + {1'b0, disp_rdata};
    cum_next = cum_sum[CNT_W] ? '1 : cum_sum[CNT_W-1:0];
    hit_now  = !found && (TOT_W'(cum_next) >= target);
    prod     = {{PCT_W{1'b0}}, total} * {{TOT_W{1'b0}}, bus.percent};
  end

  // Bank port steering: INIT clears, accumulating bank takes RMW writes or scan zeroing.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_we[b]    = 1'b0;
      bank_waddr[b] = '0;
      bank_wdata[b] = '0;
      bank_raddr[b] = (bank_sel == 1'(b)) ? bus.gray
                                          : (scan_issue ? scan_addr : bus.read_addr);
      if (state == ST_INIT) begin
        bank_we[b]    = 1'b1;
        bank_waddr[b] = init_idx;
      end else if (bank_sel == 1'(b)) begin
        if (s1_valid) begin
          bank_we[b]    = 1'b1;
          bank_waddr[b] = s1_addr;
          bank_wdata[b] = inc_val;
        end else if (scan_issue) begin
          bank_we[b]    = 1'b1;
          bank_waddr[b] = scan_addr;
        end
      end
    end
    cum_we    = (state == ST_INIT) || scan_acc;
    cum_waddr = (state == ST_INIT) ? init_idx : acc_idx;
    cum_wdata = (state == ST_INIT) ? '0 : cum_next;
  end

  // Threshold stage, evaluated against the threshold in effect this cycle.
  always_comb begin
    pix_next = '0;
    case (mode_e'(bus.mode))
      MODE_INV:  pix_next = (bus.gray > thresh_q) ? '0 : '1;
      MODE_GRAY: pix_next = bus.gray;
      default:   pix_next = (bus.gray > thresh_q) ? '1 : '0;
    endcase
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    histo_thresh_engine_ram #(.AW(PIX_W), .DW(CNT_W)) u_bank (
      .clk   (clk),
      .we    (bank_we[b]),
      .waddr (bank_waddr[b]),
      .wdata (bank_wdata[b]),
      .raddr (bank_raddr[b]),
      .rdata (bank_rdata[b])
    );
  end

  histo_thresh_engine_ram #(.AW(PIX_W), .DW(CNT_W)) u_cum (
    .clk   (clk),
    .we    (cum_we),
    .waddr (cum_waddr),
    .wdata (cum_wdata),
    .raddr (bus.read_addr),
    .rdata (cum_rdata)
  );

  // FSM, RMW pipeline registers, scan accumulator and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_INIT;
      init_idx       <= '0;
      scan_cnt       <= '0;
      drain_cnt      <= 1'b0;
      bank_sel       <= 1'b0;
      fval_d         <= 1'b0;
      s1_valid       <= 1'b0;
      s1_addr        <= '0;
      s2_valid       <= 1'b0;
      s2_addr        <= '0;
      s2_data        <= '0;
      total          <= '0;
      target         <= '0;
      cum            <= '0;
      found          <= 1'b0;
      cand           <= '0;
      disp_own_q     <= 1'b0;
      disp_sel_q     <= 1'b0;
      histo_q        <= '0;
      cum_histo_q    <= '0;
      thresh_q       <= '0;
      thresh_valid_q <= 1'b0;
      pixel_q        <= '0;
      pixel_valid_q  <= 1'b0;
      busy_q         <= 1'b0;
      frame_drop_q   <= 1'b0;
    end else begin
      thresh_valid_q <= 1'b0;
      frame_drop_q   <= 1'b0;
      fval_d         <= bus.fval;
      pixel_q        <= pix_next;
      pixel_valid_q  <= bus.gray_valid;
      busy_q         <= (state == ST_INIT) || (state == ST_SCAN);
      s1_valid       <= acc_hit;
      s1_addr        <= bus.gray;
      s2_valid       <= s1_valid;
      s2_addr        <= s1_addr;
      s2_data        <= inc_val;
      disp_own_q     <= !scan_issue;
      disp_sel_q     <= ~bank_sel;
      cum_histo_q    <= cum_rdata;
      // oHisto holds its last value while the scan owns the display-bank read port.
      if (disp_own_q) histo_q <= bank_rdata[disp_sel_q];
      if (fval_rise && (state != ST_IDLE)) frame_drop_q <= 1'b1;

      case (state)
        ST_INIT: begin
          init_idx <= init_idx + PIX_W'(1);
          if (init_idx == PIX_W'(NBINS - 1)) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (fval_rise) begin
            state <= ST_ACCUM;
            total <= TOT_W'(acc_hit);
          end
        end
        ST_ACCUM: begin
          total <= total + TOT_W'(acc_hit);
          if (fval_fall) begin
            target    <= prod[PRW-1:PCT_W];
            drain_cnt <= 1'b0;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt) begin
            bank_sel <= ~bank_sel;
            scan_cnt <= '0;
            cum      <= '0;
            found    <= 1'b0;
            cand     <= '0;
            state    <= ST_SCAN;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        ST_SCAN: begin
          scan_cnt <= scan_cnt + SCW'(1);
          if (scan_acc) begin
            cum <= cum_next;
            if (hit_now) begin
              found <= 1'b1;
              cand  <= acc_idx;
            end
          end
          if (scan_cnt[PIX_W]) begin
            thresh_q       <= found ? cand : (hit_now ? acc_idx : '1);
            thresh_valid_q <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
